// File: rtl/rv3n_fetch_align.sv
// Fetch alignment buffer: collects fetch beats as halfwords and offers up to PNUM
// decoded-length (RVC / 32-bit) instructions per cycle, with PC, error and prediction.
module rv3n_fetch_align #(
    parameter int FNUM  = 2,
    parameter int PNUM  = 2,
    parameter int BEATS = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush_valid,
    input  logic [31:0]                           flush_pc,
    input  logic                                  if_valid,
    input  logic [FNUM*32-1:0]                    if_rdata,
    input  logic                                  if_err,
    input  logic [2*FNUM-1:0]                     if_predict,
    output logic                                  if_continue,
    output logic [PNUM-1:0]                       out_valid,
    output logic [PNUM*32-1:0]                    out_instr,
    output logic [PNUM*32-1:0]                    out_pc,
    output logic [PNUM-1:0]                       out_err,
    output logic [PNUM-1:0]                       out_predict,
    output logic [PNUM-1:0]                       out_rvc,
    input  logic [$clog2(PNUM+1)-1:0]             out_take,
    output logic [$clog2(BEATS*2*FNUM+1)-1:0]     occupancy,
    output logic                                  overflow
);

    localparam int HW   = 2 * FNUM;
    localparam int SIZE = BEATS * HW;
    localparam int TW   = $clog2(PNUM + 1);
    localparam int OW   = $clog2(SIZE + 1);
    localparam int IW   = OW + 1;
    localparam int FW   = $clog2(HW);

    logic [15:0]      hw_r [SIZE];
    logic [SIZE-1:0]  err_r;
    logic [SIZE-1:0]  pred_r;
    logic [OW-1:0]    len_r;
    logic [31:0]      pc_r;
    logic [FW-1:0]    off_r;
    logic             ovf_r;

    logic [IW-1:0]    pos_s;
    logic             chain_s;
    logic [15:0]      lo_s [PNUM];
    logic [15:0]      hi_s [PNUM];
    logic [PNUM-1:0]  elo_s, ehi_s, plo_s, phi_s;
    logic [PNUM-1:0]  rvc_s, valid_s, err_s, pred_s;
    logic [IW-1:0]    end_s [PNUM];
    logic [31:0]      instr_s [PNUM];
    logic [31:0]      pc_s [PNUM];

    logic [TW-1:0]    vcnt_s, take_s;
    logic [IW-1:0]    used_s;
    logic [OW-1:0]    ret_s, app_s, next_len_s;
    logic             fits_s, accept_s, drop_s;

    logic [FNUM*32-1:0] beat_sh_s;
    logic [HW-1:0]      pbeat_sh_s;
    logic [15:0]        sh_hw_s [SIZE];
    logic [15:0]        app_hw_s [SIZE];
    logic [15:0]        nhw_s [SIZE];
    logic [SIZE-1:0]    sh_err_s, sh_pred_s, app_hit_s, app_err_s, app_pred_s;
    logic [SIZE-1:0]    nerr_s, npred_s;

    // Slot decode: walk the buffer from index 0, sizing each instruction by its low bits
    always_comb begin
        pos_s   = '0;
        chain_s = 1'b1;
        elo_s   = '0;
        ehi_s   = '0;
        plo_s   = '0;
        phi_s   = '0;
        rvc_s   = '0;
        valid_s = '0;
        err_s   = '0;
        pred_s  = '0;
        for (int i = 0; i < PNUM; i++) begin
            lo_s[i] = 16'h0000;
            hi_s[i] = 16'h0000;
            for (int j = 0; j < SIZE; j++) begin
                lo_s[i]  = lo_s[i] | ({16{IW'(j) == pos_s}} & hw_r[j]);
                hi_s[i]  = hi_s[i] | ({16{IW'(j) == pos_s + IW'(1)}} & hw_r[j]);
                elo_s[i] = elo_s[i] | ((IW'(j) == pos_s) & err_r[j]);
                ehi_s[i] = ehi_s[i] | ((IW'(j) == pos_s + IW'(1)) & err_r[j]);
                plo_s[i] = plo_s[i] | ((IW'(j) == pos_s) & pred_r[j]);
                phi_s[i] = phi_s[i] | ((IW'(j) == pos_s + IW'(1)) & pred_r[j]);
            end
            rvc_s[i]   = (lo_s[i][1:0] != 2'b11);
            end_s[i]   = pos_s + (rvc_s[i] ? IW'(1) : IW'(2));
            valid_s[i] = chain_s && (end_s[i] <= IW'(len_r));
            instr_s[i] = rvc_s[i] ? {16'h0000, lo_s[i]} : {hi_s[i], lo_s[i]};
            pc_s[i]    = pc_r + 32'({pos_s, 1'b0});
            err_s[i]   = elo_s[i] | (~rvc_s[i] & ehi_s[i]);
            pred_s[i]  = plo_s[i] | (~rvc_s[i] & phi_s[i]);
            // a predicted-taken slot ends the group offered this cycle
            chain_s    = valid_s[i] && !pred_s[i];
            pos_s      = end_s[i];
        end
    end

    // Consumption, beat acceptance and next length
    always_comb begin
        vcnt_s = '0;
        for (int i = 0; i < PNUM; i++) begin
            vcnt_s = vcnt_s + TW'(valid_s[i]);
        end
        take_s = (out_take > vcnt_s) ? vcnt_s : out_take;
        used_s = '0;
        for (int i = 0; i < PNUM; i++) begin
            used_s = (TW'(i) < take_s) ? end_s[i] : used_s;
        end
        ret_s      = len_r - OW'(used_s);
        app_s      = OW'(HW) - OW'(off_r);
        fits_s     = (IW'(ret_s) + IW'(app_s)) <= IW'(SIZE);
        accept_s   = if_valid && fits_s && !flush_valid && !rst;
        drop_s     = if_valid && !fits_s && !flush_valid;
        next_len_s = (rst || flush_valid) ? '0 : (accept_s ? ret_s + app_s : ret_s);
    end

    assign if_continue = (next_len_s <= OW'(SIZE - HW));

    // Next buffer contents: retained halfwords shifted down, new beat appended after them
    always_comb begin
        beat_sh_s  = if_rdata >> {off_r, 4'b0000};
        pbeat_sh_s = if_predict >> off_r;
        sh_err_s   = '0;
        sh_pred_s  = '0;
        app_hit_s  = '0;
        app_err_s  = '0;
        app_pred_s = '0;
        for (int j = 0; j < SIZE; j++) begin
            sh_hw_s[j]  = 16'h0000;
            app_hw_s[j] = 16'h0000;
            for (int k = 0; k < SIZE; k++) begin
                sh_hw_s[j]   = sh_hw_s[j] | ({16{IW'(k) == IW'(j) + used_s}} & hw_r[k]);
                sh_err_s[j]  = sh_err_s[j] | ((IW'(k) == IW'(j) + used_s) & err_r[k]);
                sh_pred_s[j] = sh_pred_s[j] | ((IW'(k) == IW'(j) + used_s) & pred_r[k]);
            end
            for (int k = 0; k < HW; k++) begin
                app_hit_s[j]  = app_hit_s[j] | (accept_s && (IW'(j) == IW'(ret_s) + IW'(k))
                                                && (OW'(k) < app_s));
                app_hw_s[j]   = app_hw_s[j] | ({16{IW'(j) == IW'(ret_s) + IW'(k)}}
                                               & beat_sh_s[16*k +: 16]);
                app_pred_s[j] = app_pred_s[j] | ((IW'(j) == IW'(ret_s) + IW'(k)) & pbeat_sh_s[k]);
            end
            app_err_s[j] = if_err;
            nhw_s[j]     = app_hit_s[j] ? app_hw_s[j] : sh_hw_s[j];
            nerr_s[j]    = app_hit_s[j] ? app_err_s[j] : sh_err_s[j];
            npred_s[j]   = app_hit_s[j] ? app_pred_s[j] : sh_pred_s[j];
        end
    end

    // Buffer state: reset dominates flush, flush dominates consume/append
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < SIZE; j++) begin
                hw_r[j] <= 16'h0000;
            end
            err_r  <= '0;
            pred_r <= '0;
            len_r  <= '0;
            pc_r   <= 32'h0000_0000;
            off_r  <= '0;
            ovf_r  <= 1'b0;
        end else if (flush_valid) begin
            len_r  <= '0;
            pc_r   <= flush_pc & 32'hFFFF_FFFE;
            off_r  <= flush_pc[FW:1];
            ovf_r  <= 1'b0;
        end else begin
            hw_r   <= nhw_s;
            err_r  <= nerr_s;
            pred_r <= npred_s;
            len_r  <= next_len_s;
            pc_r   <= pc_r + 32'({used_s, 1'b0});
            if (accept_s) begin
                off_r <= '0;
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    // Output packing
    always_comb begin
        for (int i = 0; i < PNUM; i++) begin
            out_instr[32*i +: 32] = instr_s[i];
            out_pc[32*i +: 32]    = pc_s[i];
        end
        out_valid   = valid_s;
        out_err     = err_s;
        out_predict = pred_s;
        out_rvc     = rvc_s;
        occupancy   = len_r;
        overflow    = ovf_r;
    end

endmodule

// File: tb/tb_rv3n_fetch_align.sv
// Scoreboard bench for rv3n_fetch_align (FNUM=2, PNUM=2, BEATS=3): each scenario pushes
// the expected post-edge view per stimulus step and pops it when the DUT has updated.
module tb_rv3n_fetch_align;

    localparam logic [63:0] BEAT_A = 64'h00A00513_00100093;

    logic        clk = 1'b0;
    logic        rst, flush_valid, if_valid, if_err, if_continue, overflow;
    logic [31:0] flush_pc;
    logic [63:0] if_rdata, out_instr, out_pc;
    logic [3:0]  if_predict, occupancy;
    logic [1:0]  out_valid, out_err, out_predict, out_rvc, out_take;

    typedef struct packed {
        logic [1:0]  valid;
        logic [3:0]  occ;
        logic        ovf;
        logic        cont;
        logic [31:0] i0;
        logic [31:0] p0;
        logic        e0, r0, d0;
        logic [31:0] i1;
        logic [31:0] p1;
        logic        e1, r1, d1;
    } obs_t;

    typedef struct packed {
        logic        rs;
        logic        fl;
        logic [31:0] fpc;
        logic        iv;
        logic [63:0] d;
        logic        er;
        logic [3:0]  pr;
        logic [1:0]  tk;
    } stim_t;

    int   checks   = 0;
    int   failures = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    rv3n_fetch_align #(.FNUM(2), .PNUM(2), .BEATS(3)) dut (
        .clk(clk), .rst(rst), .flush_valid(flush_valid), .flush_pc(flush_pc),
        .if_valid(if_valid), .if_rdata(if_rdata), .if_err(if_err), .if_predict(if_predict),
        .if_continue(if_continue), .out_valid(out_valid), .out_instr(out_instr),
        .out_pc(out_pc), .out_err(out_err), .out_predict(out_predict), .out_rvc(out_rvc),
        .out_take(out_take), .occupancy(occupancy), .overflow(overflow)
    );

    function automatic stim_t S(logic rs, logic fl, logic [31:0] fpc, logic iv,
                                logic [63:0] d, logic er, logic [3:0] pr, logic [1:0] tk);
        stim_t s;
        s.rs = rs; s.fl = fl; s.fpc = fpc; s.iv = iv; s.d = d; s.er = er; s.pr = pr; s.tk = tk;
        return s;
    endfunction

    function automatic obs_t E(logic [1:0] v, logic [3:0] occ, logic ovf, logic cont);
        obs_t e;
        e = '0;
        e.valid = v; e.occ = occ; e.ovf = ovf; e.cont = cont;
        return e;
    endfunction

    // Fill in one slot; the RVC flag follows from the instruction's low bits
    function automatic obs_t SL(obs_t e, int idx, logic [31:0] ins, logic [31:0] pc,
                                logic er, logic pd);
        obs_t r;
        r = e;
        if (idx == 0) begin
            r.i0 = ins; r.p0 = pc; r.e0 = er; r.d0 = pd; r.r0 = (ins[1:0] != 2'b11);
        end else begin
            r.i1 = ins; r.p1 = pc; r.e1 = er; r.d1 = pd; r.r1 = (ins[1:0] != 2'b11);
        end
        return r;
    endfunction

    function automatic obs_t obs_mask(logic [1:0] v);
        obs_t m;
        m = '0;
        m.valid = 2'b11; m.occ = 4'hF; m.ovf = 1'b1; m.cont = 1'b1;
        if (v[0]) begin
            m.i0 = 32'hFFFF_FFFF; m.p0 = 32'hFFFF_FFFF; m.e0 = 1'b1; m.r0 = 1'b1; m.d0 = 1'b1;
        end
        if (v[1]) begin
            m.i1 = 32'hFFFF_FFFF; m.p1 = 32'hFFFF_FFFF; m.e1 = 1'b1; m.r1 = 1'b1; m.d1 = 1'b1;
        end
        return m;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.valid = out_valid; o.occ = occupancy; o.ovf = overflow; o.cont = if_continue;
        o.i0 = out_instr[31:0];  o.p0 = out_pc[31:0];
        o.e0 = out_err[0]; o.r0 = out_rvc[0]; o.d0 = out_predict[0];
        o.i1 = out_instr[63:32]; o.p1 = out_pc[63:32];
        o.e1 = out_err[1]; o.r1 = out_rvc[1]; o.d1 = out_predict[1];
        return o;
    endfunction

    // Drive one cycle of stimulus, then return inputs (except rst) to idle and let logic settle
    task automatic apply(input stim_t s);
        rst = s.rs; flush_valid = s.fl; flush_pc = s.fpc; if_valid = s.iv;
        if_rdata = s.d; if_err = s.er; if_predict = s.pr; out_take = s.tk;
        @(posedge clk);
        #1;
        flush_valid = 1'b0; if_valid = 1'b0; if_err = 1'b0; if_predict = 4'h0; out_take = 2'd0;
        #1;
    endtask

    task automatic test_reset();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(1'b1, 1'b1, 32'h40, 1'b1, BEAT_A, 1'b0, 4'h0, 2'd0)); ex.push_back(E(2'b00, 4'd0, 1'b0, 1'b1));
        st.push_back(S(1'b1, 1'b0, 32'h0, 1'b1, BEAT_A, 1'b1, 4'h0, 2'd0));  ex.push_back(E(2'b00, 4'd0, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0, 4'h0, 2'd0));   ex.push_back(E(2'b00, 4'd0, 1'b0, 1'b1));
        foreach (st[k]) begin
            exp_q.push_back(ex[k]);
            apply(st[k]);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (((got ^ want) & obs_mask(want.valid)) !== '0) begin
                failures++;
                $display("FAIL reset step %0d: got %h expected %h", k, got, want);
            end
        end
    endtask

    task automatic test_aligned();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(1'b0, 1'b1, 32'h80, 1'b0, 64'h0, 1'b0, 4'h0, 2'd0)); ex.push_back(E(2'b00, 4'd0, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b1, BEAT_A, 1'b0, 4'h0, 2'd0));
        ex.push_back(SL(SL(E(2'b11, 4'd4, 1'b0, 1'b1), 0, 32'h00100093, 32'h80, 1'b0, 1'b0),
                        1, 32'h00A00513, 32'h84, 1'b0, 1'b0));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0, 4'h0, 2'd2)); ex.push_back(E(2'b00, 4'd0, 1'b0, 1'b1));
        foreach (st[k]) begin
            exp_q.push_back(ex[k]);
            apply(st[k]);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (((got ^ want) & obs_mask(want.valid)) !== '0) begin
                failures++;
                $display("FAIL aligned step %0d: got %h expected %h", k, got, want);
            end
        end
    endtask

    task automatic test_offset();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(1'b0, 1'b1, 32'h82, 1'b0, 64'h0, 1'b0, 4'h0, 2'd0)); ex.push_back(E(2'b00, 4'd0, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b1, 64'h418D_4109_4085_4001, 1'b0, 4'h0, 2'd0));
        ex.push_back(SL(SL(E(2'b11, 4'd3, 1'b0, 1'b1), 0, 32'h4085, 32'h82, 1'b0, 1'b0),
                        1, 32'h4109, 32'h84, 1'b0, 1'b0));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0, 4'h0, 2'd2));
        ex.push_back(SL(E(2'b01, 4'd1, 1'b0, 1'b1), 0, 32'h418D, 32'h86, 1'b0, 1'b0));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b1, 64'h438D_4309_4285_4201, 1'b0, 4'h0, 2'd0));
        ex.push_back(SL(SL(E(2'b11, 4'd5, 1'b0, 1'b1), 0, 32'h418D, 32'h86, 1'b0, 1'b0),
                        1, 32'h4201, 32'h88, 1'b0, 1'b0));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0, 4'h0, 2'd2));
        ex.push_back(SL(SL(E(2'b11, 4'd3, 1'b0, 1'b1), 0, 32'h4285, 32'h8A, 1'b0, 1'b0),
                        1, 32'h4309, 32'h8C, 1'b0, 1'b0));
        foreach (st[k]) begin
            exp_q.push_back(ex[k]);
            apply(st[k]);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (((got ^ want) & obs_mask(want.valid)) !== '0) begin
                failures++;
                $display("FAIL offset step %0d: got %h expected %h", k, got, want);
            end
        end
    endtask

    task automatic test_straddle();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(1'b0, 1'b1, 32'h100, 1'b0, 64'h0, 1'b0, 4'h0, 2'd0)); ex.push_back(E(2'b00, 4'd0, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b1, 64'h0093_4001_4005_0001, 1'b0, 4'h0, 2'd0));
        ex.push_back(SL(SL(E(2'b11, 4'd4, 1'b0, 1'b1), 0, 32'h0001, 32'h100, 1'b0, 1'b0),
                        1, 32'h4005, 32'h102, 1'b0, 1'b0));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0, 4'h0, 2'd2));
        ex.push_back(SL(E(2'b01, 4'd2, 1'b0, 1'b1), 0, 32'h4001, 32'h104, 1'b0, 1'b0));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0, 4'h0, 2'd2)); ex.push_back(E(2'b00, 4'd1, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0, 4'h0, 2'd2)); ex.push_back(E(2'b00, 4'd1, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b1, 64'h0001_0001_0001_0010, 1'b1, 4'h0, 2'd0));
        ex.push_back(SL(SL(E(2'b11, 4'd5, 1'b0, 1'b1), 0, 32'h00100093, 32'h106, 1'b1, 1'b0),
                        1, 32'h0001, 32'h10A, 1'b1, 1'b0));
        foreach (st[k]) begin
            exp_q.push_back(ex[k]);
            apply(st[k]);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (((got ^ want) & obs_mask(want.valid)) !== '0) begin
                failures++;
                $display("FAIL straddle step %0d: got %h expected %h", k, got, want);
            end
        end
    endtask

    task automatic test_take();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        obs_t  full;
        full = SL(SL(E(2'b11, 4'd4, 1'b0, 1'b1), 0, 32'h00100093, 32'h200, 1'b0, 1'b0),
                  1, 32'h00A00513, 32'h204, 1'b0, 1'b0);
        st.push_back(S(1'b0, 1'b1, 32'h200, 1'b0, 64'h0, 1'b0, 4'h0, 2'd0)); ex.push_back(E(2'b00, 4'd0, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b1, BEAT_A, 1'b0, 4'h0, 2'd0));   ex.push_back(full);
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0, 4'h0, 2'd1));
        ex.push_back(SL(E(2'b01, 4'd2, 1'b0, 1'b1), 0, 32'h00A00513, 32'h204, 1'b0, 1'b0));
        st.push_back(S(1'b0, 1'b1, 32'h200, 1'b0, 64'h0, 1'b0, 4'h0, 2'd0)); ex.push_back(E(2'b00, 4'd0, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b1, BEAT_A, 1'b0, 4'h0, 2'd0));   ex.push_back(full);
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b0, 64'h0, 1'b0, 4'h0, 2'd3));   ex.push_back(E(2'b00, 4'd0, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b1, 64'h0000_0001_0000_0001, 1'b0, 4'h0, 2'd0));
        ex.push_back(SL(SL(E(2'b11, 4'd4, 1'b0, 1'b1), 0, 32'h0001, 32'h208, 1'b0, 1'b0),
                        1, 32'h0000, 32'h20A, 1'b0, 1'b0));
        foreach (st[k]) begin
            exp_q.push_back(ex[k]);
            apply(st[k]);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (((got ^ want) & obs_mask(want.valid)) !== '0) begin
                failures++;
                $display("FAIL take step %0d: got %h expected %h", k, got, want);
            end
        end
    endtask

    task automatic test_predict_overflow();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(1'b0, 1'b1, 32'h300, 1'b0, 64'h0, 1'b0, 4'h0, 2'd0)); ex.push_back(E(2'b00, 4'd0, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b1, BEAT_A, 1'b0, 4'b0001, 2'd0));
        ex.push_back(SL(E(2'b01, 4'd4, 1'b0, 1'b1), 0, 32'h00100093, 32'h300, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b1, BEAT_A, 1'b0, 4'h0, 2'd0));
        ex.push_back(SL(E(2'b01, 4'd8, 1'b0, 1'b1), 0, 32'h00100093, 32'h300, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b1, BEAT_A, 1'b0, 4'h0, 2'd0));
        ex.push_back(SL(E(2'b01, 4'd12, 1'b0, 1'b0), 0, 32'h00100093, 32'h300, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b1, BEAT_A, 1'b0, 4'h0, 2'd0));
        ex.push_back(SL(E(2'b01, 4'd12, 1'b1, 1'b0), 0, 32'h00100093, 32'h300, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b1, BEAT_A, 1'b0, 4'h0, 2'd1));
        ex.push_back(SL(SL(E(2'b11, 4'd10, 1'b1, 1'b0), 0, 32'h00A00513, 32'h304, 1'b0, 1'b0),
                        1, 32'h00100093, 32'h308, 1'b0, 1'b0));
        st.push_back(S(1'b0, 1'b1, 32'h400, 1'b1, BEAT_A, 1'b0, 4'h0, 2'd2)); ex.push_back(E(2'b00, 4'd0, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b1, 64'h0001_0001_0001_0001, 1'b0, 4'h0, 2'd0));
        ex.push_back(SL(SL(E(2'b11, 4'd4, 1'b0, 1'b1), 0, 32'h0001, 32'h400, 1'b0, 1'b0),
                        1, 32'h0001, 32'h402, 1'b0, 1'b0));
        foreach (st[k]) begin
            if (k == 3) begin
                // with 8 buffered, a pending beat must pull if_continue low combinationally
                if_valid = 1'b1;
                #1;
                checks++;
                if (if_continue !== 1'b0) begin
                    failures++;
                    $display("FAIL continue_comb: got %b expected 0", if_continue);
                end
            end
            exp_q.push_back(ex[k]);
            apply(st[k]);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (((got ^ want) & obs_mask(want.valid)) !== '0) begin
                failures++;
                $display("FAIL predict_overflow step %0d: got %h expected %h", k, got, want);
            end
        end
    endtask

    task automatic test_midstream_reset();
        stim_t st[$];
        obs_t  ex[$];
        obs_t  got, want;
        st.push_back(S(1'b0, 1'b1, 32'h500, 1'b0, 64'h0, 1'b0, 4'h0, 2'd0)); ex.push_back(E(2'b00, 4'd0, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b1, 64'h0093_4001_4005_0001, 1'b0, 4'h0, 2'd0));
        ex.push_back(SL(SL(E(2'b11, 4'd4, 1'b0, 1'b1), 0, 32'h0001, 32'h500, 1'b0, 1'b0),
                        1, 32'h4005, 32'h502, 1'b0, 1'b0));
        st.push_back(S(1'b1, 1'b0, 32'h0, 1'b1, 64'h0001_0001_0001_0010, 1'b0, 4'h0, 2'd1));
        ex.push_back(E(2'b00, 4'd0, 1'b0, 1'b1));
        st.push_back(S(1'b0, 1'b0, 32'h0, 1'b1, 64'h0001_0001_0005_0001, 1'b0, 4'h0, 2'd0));
        ex.push_back(SL(SL(E(2'b11, 4'd4, 1'b0, 1'b1), 0, 32'h0001, 32'h0, 1'b0, 1'b0),
                        1, 32'h0005, 32'h2, 1'b0, 1'b0));
        foreach (st[k]) begin
            exp_q.push_back(ex[k]);
            apply(st[k]);
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (((got ^ want) & obs_mask(want.valid)) !== '0) begin
                failures++;
                $display("FAIL midstream_reset step %0d: got %h expected %h", k, got, want);
            end
        end
    endtask

    initial begin
        rst = 1'b1; flush_valid = 1'b0; flush_pc = 32'h0; if_valid = 1'b0;
        if_rdata = 64'h0; if_err = 1'b0; if_predict = 4'h0; out_take = 2'd0;
        #2;
        test_reset();
        test_aligned();
        test_offset();
        test_straddle();
        test_take();
        test_predict_overflow();
        test_midstream_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
